// File: rtl/piso_serializer_if.sv
// Handshake and serial-link bundle for piso_serializer.
// master = word source / link pacer, slave = the serializer itself.
`timescale 1ns/1ps
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             frame_done;
    logic             busy;

    modport master (
        output din, load_valid, shift_en,
        input  load_ready, sout, sout_valid, frame_start, frame_done, busy
    );

    modport slave (
        input  din, load_valid, shift_en,
        output load_ready, sout, sout_valid, frame_start, frame_done, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: accepts a WIDTH-bit word on a valid/ready
// handshake and emits it one bit per shift_en, frames optionally back-to-back.
`timescale 1ns/1ps
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    piso_serializer_if.slave   bus
);
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sreg_reg, sreg_next, sreg_adv;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             last_bit, accept, busy;

    // One-position advance toward the output end with zero fill.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_adv
        if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_fill
                assign sreg_adv[gi] = 1'b0;
            end else begin : g_move
                assign sreg_adv[gi] = sreg_reg[gi-1];
            end
        end else begin : g_lsb
            if (gi == WIDTH - 1) begin : g_fill
                assign sreg_adv[gi] = 1'b0;
            end else begin : g_move
                assign sreg_adv[gi] = sreg_reg[gi+1];
            end
        end
    end

    assign busy     = (state_reg == SHIFT);
    assign last_bit = (cnt_reg == LAST);
    // The only combinational path through the block: shift_en -> load_ready.
    assign bus.load_ready = !busy || (last_bit && bus.shift_en);
    assign accept         = bus.load_valid && bus.load_ready;

    always_comb begin
        state_next = state_reg;
        sreg_next  = sreg_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                    sreg_next  = bus.din;
                    cnt_next   = '0;
                end
            end
            SHIFT: begin
                if (bus.shift_en) begin
                    if (!last_bit) begin
                        cnt_next  = cnt_reg + CW'(1);
                        sreg_next = sreg_adv;
                    end else if (accept) begin
                        sreg_next = bus.din;
                        cnt_next  = '0;
                    end else begin
                        // Clearing sreg drives sout low once the frame ends.
                        state_next = IDLE;
                        sreg_next  = '0;
                        cnt_next   = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sreg_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sreg_reg  <= sreg_next;
            cnt_reg   <= cnt_next;
        end
    end

    // sout is the output-end flop of the shift register itself.
    assign bus.sout        = MSB_FIRST ? sreg_reg[WIDTH-1] : sreg_reg[0];
    assign bus.busy        = busy;
    assign bus.sout_valid  = busy;
    assign bus.frame_start = busy && (cnt_reg == '0);
    assign bus.frame_done  = busy && last_bit;
endmodule
